sync_fifo_ctrl: RTL and testbench

Synchronous single-clock FIFO built around the dp_sram two-port memory. Owns the write/read pointers, occupancy count and status flags. Drives dp_sram's active-low chip-select, write and read strobes, and exposes a simple valid-style push/pop interface to the surrounding datapath. dp_sram is instantiated inside this block as the storage array.

---
 rtl/sync_fifo_ctrl_pkg.sv | 22 ++
 rtl/dp_sram.sv | 47 ++++
 rtl/sync_fifo_ctrl.sv | 115 +++++++++++
 tb/tb_sync_fifo_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_ctrl_pkg
// Shared constants for the synchronous FIFO controller and its storage array.
// Holds the default geometry (word width, address width), the derived depth,
// pointer and count widths, and the default almost-full / almost-empty
// thresholds.
// -----------------------------------------------------------------------------
package sync_fifo_ctrl_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_ADDR_WIDTH = 4;

   // Derived from the default geometry.
   localparam int DEPTH     = 2 ** DEF_ADDR_WIDTH;
   localparam int PTR_WIDTH = DEF_ADDR_WIDTH + 1;
   localparam int CNT_WIDTH = DEF_ADDR_WIDTH + 1;

   // Default flag thresholds.
   localparam int DEF_AFULL_LVL  = 14;
   localparam int DEF_AEMPTY_LVL = 2;

endpackage

// File: rtl/dp_sram.sv
// -----------------------------------------------------------------------------
// dp_sram
// Two-port synchronous SRAM with one write port (A) and one read port (B).
// All strobes are active low. The read port has a registered output that loads
// only on an enabled read and holds its value otherwise. The output register
// is not reset. A same-address read and write in one cycle returns the old word.
//
// Ports:
//   clk      : clock, rising edge
//   csen_n   : chip select, active low
//   wrena_n  : port A write enable, active low
//   addra    : port A address
//   data_a   : port A write data
//   rdenb_n  : port B read enable, active low
//   addrb    : port B address
//   data_b   : port B registered read data
// -----------------------------------------------------------------------------
module dp_sram #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  csen_n,
   input  logic                  wrena_n,
   input  logic [ADDR_WIDTH-1:0] addra,
   input  logic [DATA_WIDTH-1:0] data_a,
   input  logic                  rdenb_n,
   input  logic [ADDR_WIDTH-1:0] addrb,
   output logic [DATA_WIDTH-1:0] data_b
);

   localparam int WORDS = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [WORDS];

   // Storage array and registered read port. Non-blocking updates give
   // read-old behaviour on a same-address collision.
   always_ff @(posedge clk) begin
      if (!csen_n && !wrena_n) begin
         mem[addra] <= data_a;
      end
      if (!csen_n && !rdenb_n) begin
         data_b <= mem[addrb];
      end
   end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sync_fifo_ctrl
// Single-clock FIFO controller around dp_sram. Owns the read/write pointers,
// the occupancy count, the status flags and the sticky error flags. Exposes a
// push/pop interface. Popped data appears one cycle after an accepted pop and
// is qualified by rd_valid.
//
// Ports:
//   clk          : clock, rising edge
//   rst          : asynchronous active-high reset
//   wr_en        : push request
//   wr_data      : push data
//   rd_en        : pop request
//   rd_data      : pop data, valid when rd_valid is high
//   rd_valid     : one-cycle pulse one cycle after an accepted pop
//   full         : count == DEPTH
//   empty        : count == 0
//   almost_full  : count >= AFULL_LVL
//   almost_empty : count <= AEMPTY_LVL
//   count        : current occupancy, 0..DEPTH
//   overflow     : sticky, push requested while full
//   underflow    : sticky, pop requested while empty
// -----------------------------------------------------------------------------
module sync_fifo_ctrl
   import sync_fifo_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int AFULL_LVL  = DEF_AFULL_LVL,
   parameter int AEMPTY_LVL = DEF_AEMPTY_LVL
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int FIFO_DEPTH = 2 ** ADDR_WIDTH;
   localparam int PW         = ADDR_WIDTH + 1;

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr_next;
   logic [PW-1:0] rd_ptr_next;
   logic [PW-1:0] count_next;
   logic          wa;
   logic          ra;

   // Accept decisions use the registered flags, i.e. the state at the start
   // of the cycle. A blocked side never touches the memory.
   assign wa = wr_en & ~full;
   assign ra = rd_en & ~empty;

   // Next pointers and next occupancy. The extra pointer bit makes the
   // difference of the two pointers the occupancy, including the full case.
   always_comb begin
      wr_ptr_next = wr_ptr + PW'(wa);
      rd_ptr_next = rd_ptr + PW'(ra);
      count_next  = wr_ptr_next - rd_ptr_next;
   end

   // Pointer, count and flag registers. Flags are computed from the next
   // occupancy so they stay aligned with the registered count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         rd_valid     <= 1'b0;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         wr_ptr       <= wr_ptr_next;
         rd_ptr       <= rd_ptr_next;
         count        <= count_next;
         full         <= (count_next == PW'(FIFO_DEPTH));
         empty        <= (count_next == '0);
         almost_full  <= (count_next >= PW'(AFULL_LVL));
         almost_empty <= (count_next <= PW'(AEMPTY_LVL));
         rd_valid     <= ra;
         overflow     <= overflow | (wr_en & full);
         underflow    <= underflow | (rd_en & empty);
      end
   end

   // Storage array. The chip is permanently selected.
   dp_sram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_dp_sram (
      .clk     (clk),
      .csen_n  (1'b0),
      .wrena_n (~wa),
      .addra   (wr_ptr[ADDR_WIDTH-1:0]),
      .data_a  (wr_data),
      .rdenb_n (~ra),
      .addrb   (rd_ptr[ADDR_WIDTH-1:0]),
      .data_b  (rd_data)
   );

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_ctrl
// Self-checking bench for sync_fifo_ctrl. A queue-based model of the FIFO
// predicts occupancy, flags, sticky errors and popped data. Every stimulus
// cycle is compared against the model, and a few literal values pin the model.
// -----------------------------------------------------------------------------
module tb_sync_fifo_ctrl;
   import sync_fifo_ctrl_pkg::*;

   logic                 clk;
   logic                 rst;
   logic                 wr_en;
   logic [7:0]           wr_data;
   logic                 rd_en;
   logic [7:0]           rd_data;
   logic                 rd_valid;
   logic                 full;
   logic                 empty;
   logic                 almost_full;
   logic                 almost_empty;
   logic [CNT_WIDTH-1:0] count;
   logic                 overflow;
   logic                 underflow;

   int vectors;
   int miscompares;

   // Reference model state.
   logic [7:0] model_q [$];
   logic       m_ovf;
   logic       m_unf;
   logic       m_valid;
   logic [7:0] m_data;

   sync_fifo_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison with failure reporting.
   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare every DUT output against the model.
   task automatic checkOutput();
      int n;
      n = model_q.size();
      checkVal("count",        32'(count),        32'(n));
      checkVal("empty",        32'(empty),        32'(n == 0));
      checkVal("full",         32'(full),         32'(n == DEPTH));
      checkVal("almost_full",  32'(almost_full),  32'(n >= DEF_AFULL_LVL));
      checkVal("almost_empty", 32'(almost_empty), 32'(n <= DEF_AEMPTY_LVL));
      checkVal("rd_valid",     32'(rd_valid),     32'(m_valid));
      checkVal("overflow",     32'(overflow),     32'(m_ovf));
      checkVal("underflow",    32'(underflow),    32'(m_unf));
      if (m_valid) begin
         checkVal("rd_data", 32'(rd_data), 32'(m_data));
      end
   endtask

   // Model reset: empty queue, sticky flags and pending read cleared.
   task automatic modelReset();
      model_q.delete();
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      m_valid = 1'b0;
      m_data  = 8'h00;
   endtask

   // Drive one cycle of requests, advance the model, clock, then check.
   task automatic applyStimulus(input logic wr, input logic rd, input logic [7:0] data);
      int n;
      wr_en   = wr;
      rd_en   = rd;
      wr_data = data;
      n = model_q.size();
      if (wr && n == DEPTH) m_ovf = 1'b1;
      if (rd && n == 0)     m_unf = 1'b1;
      m_valid = 1'b0;
      if (rd && n > 0) begin
         m_data  = model_q.pop_front();
         m_valid = 1'b1;
      end
      if (wr && n < DEPTH) model_q.push_back(data);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst     = 1'b1;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      wr_data = 8'h00;
      modelReset();
      @(posedge clk);
      @(posedge clk);
      #1;
      checkOutput();
      rst = 1'b0;

      // Fill with 0x00..0x0F.
      for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, 8'(i));
      checkVal("fill_count_lit", 32'(count), 32'd16);
      checkVal("fill_full_lit",  32'(full),  32'd1);

      // Overflow: push while full is rejected and sets the sticky flag.
      applyStimulus(1'b1, 1'b0, 8'hAA);
      checkVal("ovf_lit",       32'(overflow), 32'd1);
      checkVal("ovf_count_lit", 32'(count),    32'd16);

      // Drain; first word must be the original oldest word.
      applyStimulus(1'b0, 1'b1, 8'h00);
      checkVal("first_pop_lit", 32'(rd_data), 32'h00);
      for (int i = 1; i < 16; i++) applyStimulus(1'b0, 1'b1, 8'h00);
      checkVal("last_pop_lit", 32'(rd_data), 32'h0F);
      applyStimulus(1'b0, 1'b0, 8'h00);

      // Underflow on empty FIFO.
      applyStimulus(1'b0, 1'b1, 8'h00);
      checkVal("unf_lit",   32'(underflow), 32'd1);
      checkVal("unf_valid", 32'(rd_valid),  32'd0);

      // Simultaneous push/pop while empty: write wins, count becomes 1.
      applyStimulus(1'b1, 1'b1, 8'h51);
      checkVal("sim_empty_count_lit", 32'(count), 32'd1);

      // Bring to 5 entries, then 20 simultaneous cycles across the wrap.
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 8'($urandom));
      for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1, 8'($urandom));
      checkVal("sim_count5_lit", 32'(count), 32'd5);

      // Fill, then simultaneous push/pop while full: read only.
      for (int i = 0; i < 11; i++) applyStimulus(1'b1, 1'b0, 8'($urandom));
      applyStimulus(1'b1, 1'b1, 8'h77);
      checkVal("sim_full_count_lit", 32'(count), 32'd15);

      // Random traffic with gaps.
      for (int i = 0; i < 300; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
      end

      // Reset mid-operation with data in flight.
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 8'($urandom));
      applyStimulus(1'b0, 1'b1, 8'h00);
      wr_en = 1'b0;
      rd_en = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      modelReset();
      checkOutput();
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < 100; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
